// File: rtl/mod_sub24_pipe.sv
// Two-stage pipelined subtractor: raw WIDTH-bit a - b - borrow_in, or (a - b) mod MOD.
// Stage 1 does a segmented borrow-lookahead subtract; stage 2 applies the modular correction.
module mod_sub24_pipe #(
  parameter int               WIDTH = 24,
  parameter logic [WIDTH-1:0] MOD   = WIDTH'(786433)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  input  logic             mod_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             range_err,
  input  logic             err_clr
);

  localparam int SEG  = 6;
  localparam int NSEG = WIDTH / SEG;

  // Pipeline state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_d_q, s1_d_d;
  logic             s1_borrow_q, s1_borrow_d;
  logic             s1_mod_q, s1_mod_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_diff_q, s2_diff_d;
  logic             s2_borrow_q, s2_borrow_d;
  logic             range_err_q, range_err_d;

  // Handshake
  logic in_fire;
  logic s2_adv;
  logic s2_load;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s2_adv;

  // Segment generate/propagate and borrow lookahead
  logic             bin_eff;
  logic [NSEG-1:0]  seg_g;
  logic [NSEG-1:0]  seg_p;
  logic [NSEG-1:0]  seg_bo;
  logic [NSEG-1:0]  seg_bi;
  logic             la_bo;
  logic             la_chain_p;

  assign bin_eff = mod_en ? 1'b0 : borrow_in;

  for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
    logic [SEG-1:0] a_seg;
    logic [SEG-1:0] b_seg;
    assign a_seg     = a_in[gi*SEG +: SEG];
    assign b_seg     = b_in[gi*SEG +: SEG];
    assign seg_g[gi] = a_seg < b_seg;
    assign seg_p[gi] = a_seg == b_seg;
    if (gi == 0) begin : g_first
      assign seg_bi[gi] = bin_eff;
    end else begin : g_rest
      assign seg_bi[gi] = seg_bo[gi-1];
    end
    assign s1_d_d[gi*SEG +: SEG] = a_seg - b_seg - {{(SEG-1){1'b0}}, seg_bi[gi]};
  end

  // Each segment's borrow-out is a flat OR of generate terms gated by higher propagates,
  // so no segment waits on its neighbour's result.
  always_comb begin
    seg_bo     = '0;
    la_bo      = 1'b0;
    la_chain_p = 1'b0;
    for (int s = 0; s < NSEG; s++) begin
      la_bo      = seg_g[s];
      la_chain_p = seg_p[s];
      for (int j = s - 1; j >= 0; j--) begin
        la_bo      = la_bo | (la_chain_p & seg_g[j]);
        la_chain_p = la_chain_p & seg_p[j];
      end
      la_bo     = la_bo | (la_chain_p & bin_eff);
      seg_bo[s] = la_bo;
    end
  end

  assign s1_borrow_d = seg_bo[NSEG-1];
  assign s1_mod_d    = mod_en;

  // Next-state logic
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    s2_diff_d   = s2_diff_q;
    s2_borrow_d = s2_borrow_q;
    range_err_d = range_err_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d  = 1'b1;
      s2_diff_d   = (s1_mod_q && s1_borrow_q) ? s1_d_q + MOD : s1_d_q;
      s2_borrow_d = s1_borrow_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    // A new error in the same cycle as a clear keeps the flag set.
    if (err_clr) begin
      range_err_d = 1'b0;
    end
    if (in_fire && mod_en && ((a_in >= MOD) || (b_in >= MOD))) begin
      range_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_d_q      <= '0;
      s1_borrow_q <= 1'b0;
      s1_mod_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_diff_q   <= '0;
      s2_borrow_q <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s2_diff_q   <= s2_diff_d;
      s2_borrow_q <= s2_borrow_d;
      range_err_q <= range_err_d;
      if (in_fire) begin
        s1_d_q      <= s1_d_d;
        s1_borrow_q <= s1_borrow_d;
        s1_mod_q    <= s1_mod_d;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign diff       = s2_diff_q;
  assign borrow_out = s2_borrow_q;
  assign range_err  = range_err_q;

endmodule

// File: tb/tb_mod_sub24_pipe.sv
// Scoreboard bench for mod_sub24_pipe: driver pushes expected results, monitor pops on output transfer.
module tb_mod_sub24_pipe;

  localparam int W = 24;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          borrow_in;
  logic          mod_en;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  diff;
  logic          borrow_out;
  logic          range_err;
  logic          err_clr;

  int checks;
  int failures;
  logic [W:0] sb[$];

  mod_sub24_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .borrow_in(borrow_in), .mod_en(mod_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow_out(borrow_out),
    .range_err(range_err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s value=0x%0h", name, act);
    end
  endtask

  // Monitor: one comparison per output transfer
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual diff=0x%0h borrow=%0b required none", diff, borrow_out);
      end else begin
        logic [W:0] e;
        e = sb.pop_front();
        check("result", {borrow_out, diff}, e);
      end
    end
  end

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                      input logic m, input logic [W-1:0] ed, input logic eb);
    bit accepted;
    accepted = 0;
    a_in = a; b_in = b; borrow_in = bin; mod_en = m; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1;
        break;
      end
    end
    if (!accepted) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual in_ready=0 required 1");
    end else begin
      sb.push_back({eb, ed});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual pending=%0d required 0", sb.size());
      sb.delete();
    end
  endtask

  logic [W-1:0] bp_a[4];
  logic [W-1:0] bp_b[4];
  logic [W-1:0] held_diff;
  int           acc;
  int           k;
  bit           seen_out;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; borrow_in = 1'b0;
    mod_en = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", {24'd0, in_ready}, 25'd1);
    check("reset_out_valid", {24'd0, out_valid}, 25'd0);
    check("reset_result", {borrow_out, diff}, 25'd0);
    check("reset_range_err", {24'd0, range_err}, 25'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: valid appears on the second edge after acceptance
    send(24'd5, 24'd3, 1'b0, 1'b1, 24'd2, 1'b0);
    @(negedge clk);
    check("latency_edge1_out_valid", {24'd0, out_valid}, 25'd0);
    @(negedge clk);
    check("latency_edge2_out_valid", {24'd0, out_valid}, 25'd1);
    @(posedge clk); #1;
    drain();

    // Directed vectors, back to back
    send(24'd3,       24'd5,       1'b0, 1'b1, 24'd786431,  1'b1);
    send(24'd0,       24'd786432,  1'b0, 1'b1, 24'd1,       1'b1);
    send(24'd0,       24'd1,       1'b0, 1'b0, 24'hFFFFFF,  1'b1);
    send(24'h000040,  24'h000001,  1'b1, 1'b0, 24'h00003E,  1'b0);
    send(24'd1000,    24'd1000,    1'b0, 1'b1, 24'd0,       1'b0);
    send(24'd10,      24'd4,       1'b1, 1'b1, 24'd6,       1'b0);
    send(24'h123456,  24'h012345,  1'b0, 1'b0, 24'h111111,  1'b0);
    send(24'h800000,  24'h000001,  1'b1, 1'b0, 24'h7FFFFE,  1'b0);
    send(24'hFFFFFF,  24'hFFFFFF,  1'b1, 1'b0, 24'hFFFFFF,  1'b1);
    drain();

    // Backpressure: only two results buffer, output holds steady
    bp_a = '{24'd100, 24'd200, 24'd300, 24'd400};
    bp_b = '{24'd1, 24'd2, 24'd3, 24'd4};
    out_ready = 1'b0;
    acc = 0; k = 0; seen_out = 0; held_diff = '0;
    a_in = bp_a[0]; b_in = bp_b[0]; borrow_in = 1'b0; mod_en = 1'b0; in_valid = 1'b1;
    repeat (6) begin
      bit took;
      @(negedge clk);
      took = in_valid && in_ready;
      if (took) begin
        sb.push_back({1'b0, bp_a[k] - bp_b[k]});
        acc++;
      end
      if (out_valid && !seen_out) begin
        seen_out = 1;
        held_diff = diff;
      end
      @(posedge clk); #1;
      if (took) begin
        k++;
        a_in = bp_a[k]; b_in = bp_b[k];
      end
    end
    @(negedge clk);
    check("bp_accepted", 25'(acc), 25'd2);
    check("bp_in_ready", {24'd0, in_ready}, 25'd0);
    check("bp_diff_stable", {1'b0, diff}, {1'b0, held_diff});
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(bp_a[2], bp_b[2], 1'b0, 1'b0, 24'd297, 1'b0);
    send(bp_a[3], bp_b[3], 1'b0, 1'b0, 24'd396, 1'b0);
    drain();

    // Sticky range error
    send(24'd786433, 24'd0, 1'b0, 1'b1, 24'd786433, 1'b0);
    check("range_err_set", {24'd0, range_err}, 25'd1);
    repeat (3) @(posedge clk);
    #1;
    check("range_err_sticky", {24'd0, range_err}, 25'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("range_err_cleared", {24'd0, range_err}, 25'd0);
    err_clr = 1'b1;
    send(24'd0, 24'd800000, 1'b0, 1'b1, 24'd16763649, 1'b1);
    err_clr = 1'b0;
    check("range_err_set_wins", {24'd0, range_err}, 25'd1);
    drain();

    // Reset with two results in flight
    out_ready = 1'b0;
    send(24'd7, 24'd2, 1'b0, 1'b0, 24'd5, 1'b0);
    send(24'd9, 24'd4, 1'b0, 1'b0, 24'd5, 1'b0);
    @(negedge clk);
    check("inflight_out_valid", {24'd0, out_valid}, 25'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", {24'd0, out_valid}, 25'd0);
    check("async_reset_range_err", {24'd0, range_err}, 25'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    seen_out = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen_out = 1;
    end
    check("no_stale_after_reset", {24'd0, seen_out}, 25'd0);
    @(posedge clk); #1;

    // Pipeline still works after reset
    send(24'd20, 24'd30, 1'b0, 1'b1, 24'd786423, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
